fp_align_pre: RTL and testbench

Pre-normalization alignment front end of the single-precision FP adder, the counterpart to the post-normalization exponent adjust stage at the back end. It unpacks two IEEE-754 operands and orders them by magnitude. It then right-shifts the smaller significand by the exponent difference, collecting guard/round/sticky bits, and hands the aligned pair plus a common exponent to the mantissa adder. It is a 2-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_align_pre.sv | 144 ++++++++++++++
 tb/tb_fp_align_pre.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fp_align_pre.sv
// Unpacks two IEEE-754 operands, orders them by magnitude and right-aligns the smaller significand with G/R/S collection.
// 2-cycle latency, 1/cycle throughput; valid/ready on both sides, stages hold their data while stalled.
module fp_align_pre #(
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_MAN  = 23,
    parameter int SIZE_DATA = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE_DATA-1:0]  i_a,
    input  logic [SIZE_DATA-1:0]  i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_EXP-1:0]   o_exp_common,
    output logic [SIZE_MAN+3:0]   o_man_big,
    output logic [SIZE_MAN+3:0]   o_man_small,
    output logic                  o_sign_big,
    output logic                  o_eff_sub,
    output logic                  o_swap,
    output logic                  o_nan,
    output logic                  o_inf,
    output logic                  o_zero
);
    localparam int W   = SIZE_MAN + 4;
    localparam int MAG = SIZE_EXP + SIZE_MAN;
    localparam logic [SIZE_EXP-1:0] SHIFT_LIM = SIZE_EXP'(W);

    logic s1_valid, s2_valid, s1_adv, s2_adv;

    assign s2_adv  = !s2_valid || i_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign o_ready = s1_adv;
    assign o_valid = s2_valid;

    // Unpack and order operands
    logic [SIZE_EXP-1:0] exp_a, exp_b, eff_a, eff_b, eff_big, eff_small;
    logic [SIZE_MAN-1:0] frac_a, frac_b;
    logic [SIZE_MAN:0]   sig_a, sig_b, sig_big, sig_small;
    logic                swap, eff_sub, sign_big;
    logic                nan_a, nan_b, inf_a, inf_b, nan, inf, zero;

    always_comb begin
        exp_a     = i_a[SIZE_DATA-2 -: SIZE_EXP];
        exp_b     = i_b[SIZE_DATA-2 -: SIZE_EXP];
        frac_a    = i_a[SIZE_MAN-1:0];
        frac_b    = i_b[SIZE_MAN-1:0];
        eff_a     = (exp_a == '0) ? SIZE_EXP'(1) : exp_a;
        eff_b     = (exp_b == '0) ? SIZE_EXP'(1) : exp_b;
        sig_a     = {|exp_a, frac_a};
        sig_b     = {|exp_b, frac_b};
        swap      = i_b[MAG-1:0] > i_a[MAG-1:0];
        eff_sub   = i_a[SIZE_DATA-1] ^ i_b[SIZE_DATA-1];
        sign_big  = swap ? i_b[SIZE_DATA-1] : i_a[SIZE_DATA-1];
        eff_big   = swap ? eff_b : eff_a;
        eff_small = swap ? eff_a : eff_b;
        sig_big   = swap ? sig_b : sig_a;
        sig_small = swap ? sig_a : sig_b;
        nan_a     = (&exp_a) && (frac_a != '0);
        nan_b     = (&exp_b) && (frac_b != '0);
        inf_a     = (&exp_a) && (frac_a == '0);
        inf_b     = (&exp_b) && (frac_b == '0);
        nan       = nan_a || nan_b || (inf_a && inf_b && eff_sub);
        inf       = (inf_a || inf_b) && !nan;
        zero      = (i_a[MAG-1:0] == '0) && (i_b[MAG-1:0] == '0);
    end

    logic [SIZE_EXP-1:0] s1_exp, s1_diff;
    logic [SIZE_MAN:0]   s1_sig_big, s1_sig_small;
    logic                s1_sign_big, s1_eff_sub, s1_swap, s1_nan, s1_inf, s1_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid     <= 1'b0;
            s1_exp       <= '0;
            s1_diff      <= '0;
            s1_sig_big   <= '0;
            s1_sig_small <= '0;
            s1_sign_big  <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_swap      <= 1'b0;
            s1_nan       <= 1'b0;
            s1_inf       <= 1'b0;
            s1_zero      <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_exp       <= eff_big;
                s1_diff      <= eff_big - eff_small;
                s1_sig_big   <= sig_big;
                s1_sig_small <= sig_small;
                s1_sign_big  <= sign_big;
                s1_eff_sub   <= eff_sub;
                s1_swap      <= swap;
                s1_nan       <= nan;
                s1_inf       <= inf;
                s1_zero      <= zero;
            end
        end
    end

    // Alignment shift; everything shifted out collapses into bit 0
    logic [W-1:0] small_ext, shifted, lost_mask, aligned;

    always_comb begin
        small_ext = {s1_sig_small, 3'b000};
        shifted   = small_ext >> s1_diff;
        lost_mask = ~({W{1'b1}} << s1_diff);
        if (s1_diff >= SHIFT_LIM) begin
            aligned = {{(W-1){1'b0}}, |small_ext};
        end else begin
            aligned = shifted | {{(W-1){1'b0}}, |(small_ext & lost_mask)};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid     <= 1'b0;
            o_exp_common <= '0;
            o_man_big    <= '0;
            o_man_small  <= '0;
            o_sign_big   <= 1'b0;
            o_eff_sub    <= 1'b0;
            o_swap       <= 1'b0;
            o_nan        <= 1'b0;
            o_inf        <= 1'b0;
            o_zero       <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_exp_common <= s1_exp;
                o_man_big    <= {s1_sig_big, 3'b000};
                o_man_small  <= aligned;
                o_sign_big   <= s1_sign_big;
                o_eff_sub    <= s1_eff_sub;
                o_swap       <= s1_swap;
                o_nan        <= s1_nan;
                o_inf        <= s1_inf;
                o_zero       <= s1_zero;
            end
        end
    end
endmodule

// File: tb/tb_fp_align_pre.sv
// Directed self-checking bench for fp_align_pre: reset, alignment, specials, backpressure, mid-flight reset.
module tb_fp_align_pre;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_exp_common;
    logic [26:0] o_man_big, o_man_small;
    logic        o_sign_big, o_eff_sub, o_swap, o_nan, o_inf, o_zero;

    int checks = 0;
    int failures = 0;
    logic got;
    int   lat;

    always #5 i_clk = ~i_clk;

    fp_align_pre dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_exp_common(o_exp_common), .o_man_big(o_man_big), .o_man_small(o_man_small),
        .o_sign_big(o_sign_big), .o_eff_sub(o_eff_sub), .o_swap(o_swap),
        .o_nan(o_nan), .o_inf(o_inf), .o_zero(o_zero)
    );

    // Drives one pair into an empty pipe and waits (bounded) for its result.
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        got = 1'b0;
        lat = 1;
        @(posedge i_clk); #1;
        i_a = a; i_b = b; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge i_clk); #1;
            lat++;
            if (o_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_o_valid got=%0h want=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_o_ready got=%0h want=1", o_ready); end
        checks++; if (o_man_big !== 27'h0) begin failures++; $display("FAIL rst_man_big got=%0h want=0", o_man_big); end
        checks++; if ({o_nan, o_inf, o_zero} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%0b want=000", {o_nan, o_inf, o_zero}); end
        #9 i_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send_pair(32'h3F800000, 32'h3F000000);
        checks++; if (got !== 1'b1 || lat != 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", lat); end
        checks++; if (o_exp_common !== 8'h7F) begin failures++; $display("FAIL basic_exp got=%0h want=7f", o_exp_common); end
        checks++; if (o_man_big !== 27'h4000000) begin failures++; $display("FAIL basic_man_big got=%0h want=4000000", o_man_big); end
        checks++; if (o_man_small !== 27'h2000000) begin failures++; $display("FAIL basic_man_small got=%0h want=2000000", o_man_small); end
        checks++; if ({o_swap, o_eff_sub} !== 2'b00) begin failures++; $display("FAIL basic_swap_sub got=%0b want=00", {o_swap, o_eff_sub}); end
    endtask

    task automatic test_swap();
        send_pair(32'h3F000000, 32'hBF800000);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL swap_timeout got=0 want=1"); end
        checks++; if ({o_swap, o_sign_big, o_eff_sub} !== 3'b111) begin failures++; $display("FAIL swap_bits got=%0b want=111", {o_swap, o_sign_big, o_eff_sub}); end
        checks++; if (o_man_big !== 27'h4000000) begin failures++; $display("FAIL swap_man_big got=%0h want=4000000", o_man_big); end
        checks++; if (o_man_small !== 27'h2000000) begin failures++; $display("FAIL swap_man_small got=%0h want=2000000", o_man_small); end
    endtask

    task automatic test_shift();
        logic [31:0] a_vec [3] = '{32'h4B800000, 32'h4D000000, 32'h4C800000};
        logic [26:0] s_exp [3] = '{27'h0000004, 27'h0000001, 27'h0000001};
        logic [7:0]  e_exp [3] = '{8'h97, 8'h9A, 8'h99};
        for (int i = 0; i < 3; i++) begin
            send_pair(a_vec[i], 32'h3F800000);
            checks++; if (got !== 1'b1 || o_man_small !== s_exp[i]) begin failures++; $display("FAIL shift_%0d got=%0h want=%0h", i, o_man_small, s_exp[i]); end
            checks++; if (o_exp_common !== e_exp[i]) begin failures++; $display("FAIL shift_exp_%0d got=%0h want=%0h", i, o_exp_common, e_exp[i]); end
        end
    endtask

    task automatic test_specials();
        send_pair(32'h7F800000, 32'hFF800000);
        checks++; if (got !== 1'b1 || o_nan !== 1'b1 || o_inf !== 1'b0) begin failures++; $display("FAIL inf_minus_inf nan/inf got=%0b%0b want=10", o_nan, o_inf); end
        send_pair(32'h7F800000, 32'h3F800000);
        checks++; if (got !== 1'b1 || o_inf !== 1'b1 || o_nan !== 1'b0) begin failures++; $display("FAIL inf_plus_one nan/inf got=%0b%0b want=01", o_nan, o_inf); end
        send_pair(32'h7FC00000, 32'h3F800000);
        checks++; if (got !== 1'b1 || o_nan !== 1'b1) begin failures++; $display("FAIL nan_operand got=%0b want=1", o_nan); end
        send_pair(32'h00000000, 32'h80000000);
        checks++; if (got !== 1'b1 || o_zero !== 1'b1) begin failures++; $display("FAIL zero_pair got=%0b want=1", o_zero); end
        send_pair(32'h00000001, 32'h00800000);
        checks++; if (got !== 1'b1 || o_exp_common !== 8'h01) begin failures++; $display("FAIL denorm_exp got=%0h want=1", o_exp_common); end
        checks++; if (o_man_small !== 27'h0000008) begin failures++; $display("FAIL denorm_man_small got=%0h want=8", o_man_small); end
        checks++; if (o_man_big !== 27'h4000000 || o_swap !== 1'b1 || o_zero !== 1'b0) begin failures++; $display("FAIL denorm_big got=%0h swap=%0b zero=%0b want=4000000 1 0", o_man_big, o_swap, o_zero); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa [4] = '{32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000};
        logic [7:0]  pe [4] = '{8'h80, 8'h81, 8'h82, 8'h83};
        logic [26:0] ps [4] = '{27'h2000000, 27'h1000000, 27'h0800000, 27'h0400000};
        int sent = 0;
        int recv = 0;
        int first = -1;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            @(posedge i_clk); #1;
            if (o_valid && first < 0) first = cyc;
            i_ready = !(first >= 0 && cyc < first + 3);
            i_valid = (sent < 4);
            i_a = pa[sent % 4];
            i_b = 32'h3F800000;
            #1;
            if (first >= 0 && cyc < first + 3) begin
                checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL stall_o_ready cyc=%0d got=%0b want=0", cyc, o_ready); end
                checks++; if (o_valid !== 1'b1 || o_exp_common !== pe[0] || o_man_small !== ps[0]) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0h/%0h want=%0h/%0h", cyc, o_exp_common, o_man_small, pe[0], ps[0]); end
            end else if (first >= 0) begin
                checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL b2b_gap cyc=%0d got=0 want=1", cyc); end
            end
            if (o_valid && i_ready) begin
                checks++; if (o_exp_common !== pe[recv] || o_man_small !== ps[recv]) begin failures++; $display("FAIL b2b_order idx=%0d got=%0h/%0h want=%0h/%0h", recv, o_exp_common, o_man_small, pe[recv], ps[recv]); end
                recv++;
            end
            if (i_valid && o_ready) sent++;
        end
        i_valid = 1'b0;
        checks++; if (recv != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", recv); end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        @(posedge i_clk); #1;
        i_ready = 1'b0; i_valid = 1'b1; i_a = 32'h3F800000; i_b = 32'h3F000000;
        @(posedge i_clk); #1;
        i_a = 32'h40000000;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin failures++; $display("FAIL midrst_full valid/ready got=%0b%0b want=10", o_valid, o_ready); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_exp_common !== 8'h00) begin failures++; $display("FAIL midrst_async valid=%0b exp=%0h want=0 0", o_valid, o_exp_common); end
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL midrst_o_ready got=%0b want=1", o_ready); end
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_shift();
        test_specials();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
